// File: rtl/alu_issue_ctrl_if.sv
// Issue (in_*) and writeback (wb_*) handshake bundle for alu_issue_ctrl.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface alu_issue_ctrl_if #(
  parameter int W     = 64,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_unit;
  logic [3:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             in_mul_hi;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [W-1:0]     wb_data;
  logic             wb_err;

  modport master (
    output in_valid, in_unit, in_op, in_a, in_b, in_tag, in_mul_hi, wb_ready,
    input  in_ready, wb_valid, wb_tag, wb_data, wb_err
  );

  modport slave (
    input  in_valid, in_unit, in_op, in_a, in_b, in_tag, in_mul_hi, wb_ready,
    output in_ready, wb_valid, wb_tag, wb_data, wb_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the IALU/IMUL/IDIV cluster, one op in flight.
// Define ALU_MUL_HI_EN to let in_mul_hi select the upper half of the IMUL product.
module alu_issue_ctrl #(
  parameter int W       = 64,
  parameter int TAG_W   = 6,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  io,
  output logic [3:0]       alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             div_start,
  input  logic [W-1:0]     alu_res,
  input  logic [2*W-1:0]   mul_res,
  input  logic             div_busy,
  input  logic [W-1:0]     div_q
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_DSTART = 3'd2,
    S_DWAIT  = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] U_IMUL = 2'b01;
  localparam logic [1:0] U_IDIV = 2'b10;
  localparam logic [1:0] U_ILL  = 2'b11;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dfirst_q, dfirst_d;
  logic [1:0]       unit_q, unit_d;
  logic             mul_hi_q, mul_hi_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [W-1:0]     data_q, data_d;
  logic             err_q, err_d;
  logic             wb_valid_q, wb_valid_d;
  logic             div_start_q, div_start_d;
  logic             accept_s;
  logic [W-1:0]     mul_sel_s;

`ifdef ALU_MUL_HI_EN
  assign mul_sel_s = mul_hi_q ? mul_res[2*W-1:W] : mul_res[W-1:0];
`else
  logic unused_mul_s;
  assign unused_mul_s = ^{mul_hi_q, mul_res[2*W-1:W]};
  assign mul_sel_s    = mul_res[W-1:0];
`endif

  // A divider still busy from a discarded op must not see a second start.
  assign io.in_ready = (state_q == S_IDLE) && !rst &&
                       !((io.in_unit == U_IDIV) && div_busy);
  assign accept_s    = io.in_valid && io.in_ready;

  // Next-state and datapath-capture decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dfirst_d = dfirst_q;
    unit_d   = unit_q;
    mul_hi_d = mul_hi_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          tag_d    = io.in_tag;
          unit_d   = io.in_unit;
          mul_hi_d = io.in_mul_hi;
          if (io.in_unit == U_ILL) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_WB;
          end else begin
            op_d    = io.in_op;
            a_d     = io.in_a;
            b_d     = io.in_b;
            err_d   = 1'b0;
            cnt_d   = 4'd1;
            state_d = (io.in_unit == U_IDIV) ? S_DSTART : S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'(ALU_LAT)) begin
          data_d  = (unit_q == U_IMUL) ? mul_sel_s : alu_res;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DSTART: begin
        dfirst_d = 1'b1;
        state_d  = S_DWAIT;
      end
      S_DWAIT: begin
        // busy may only rise the cycle after the start pulse, so skip one cycle
        if (dfirst_q) begin
          dfirst_d = 1'b0;
        end else if (!div_busy) begin
          data_d  = div_q;
          state_d = S_WB;
        end else begin
          state_d = S_DWAIT;
        end
      end
      S_WB: begin
        if (io.wb_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wb_valid_d  = (state_d == S_WB);
    div_start_d = (state_d == S_DSTART);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      dfirst_q    <= 1'b0;
      unit_q      <= 2'b00;
      mul_hi_q    <= 1'b0;
      op_q        <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dfirst_q    <= dfirst_d;
      unit_q      <= unit_d;
      mul_hi_q    <= mul_hi_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      err_q       <= err_d;
      wb_valid_q  <= wb_valid_d;
      div_start_q <= div_start_d;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign div_start   = div_start_q;
  assign io.wb_valid = wb_valid_q;
  assign io.wb_tag   = tag_q;
  assign io.wb_data  = data_q;
  assign io.wb_err   = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: cluster/divider models, writeback scoreboard,
// directed vectors with literal expectations and latency checks.
module tb_alu_issue_ctrl;
  localparam int W       = 64;
  localparam int TAG_W   = 6;
  localparam int ALU_LAT = 3;
`ifdef ALU_MUL_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
    logic             err;
  } wb_t;

  logic           clk;
  logic           rst;
  logic [3:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_res;
  logic [2*W-1:0] mul_res;
  logic           div_start;
  logic           div_busy = 1'b0;
  logic [W-1:0]   div_q = '0;
  int             busy_len = 10;
  int             busy_cnt = 0;

  alu_issue_ctrl_if #(.W(W), .TAG_W(TAG_W)) io ();

  alu_issue_ctrl #(.W(W), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .io(io),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .div_start(div_start),
    .alu_res(alu_res), .mul_res(mul_res), .div_busy(div_busy), .div_q(div_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // IALU opcode meaning assumed by the cluster stand-in
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_op, alu_a, alu_b);
  assign mul_res = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};

  // Divider stand-in: busy for busy_len cycles after the start pulse, quotient held.
  always @(posedge clk) begin
    if (div_start) begin
      div_q    <= (alu_b == '0) ? '1 : alu_a / alu_b;
      busy_cnt <= busy_len;
      div_busy <= (busy_len > 0);
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      div_busy <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected writeback of one op, from the unit semantics alone.
  function automatic wb_t model(input logic [1:0] unit, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [TAG_W-1:0] tag, input logic hi);
    wb_t r;
    logic [2*W-1:0] p;
    p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r.tag = tag;
    r.err = 1'b0;
    case (unit)
      2'b00:   r.data = alu_fn(op, a, b);
      2'b01:   r.data = (HI_EN && hi) ? p[2*W-1:W] : p[W-1:0];
      2'b10:   r.data = (b == '0) ? '1 : a / b;
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  wb_t              exp_q[$];
  int               pushed = 0;
  int               hs_count = 0;
  int               first_wb_cyc = 0;
  int               acc_cyc = 0;
  int               ds_count = 0;
  logic [W-1:0]     last_data = '0;
  logic             last_err = 1'b0;
  logic             prev_valid = 1'b0;
  logic             stall = 1'b0;
  logic [TAG_W-1:0] st_tag = '0;
  logic [W-1:0]     st_data = '0;
  logic             st_err = 1'b0;

  // Compare process: every writeback against the scoreboard, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (div_start) ds_count <= ds_count + 1;
      if (io.wb_valid) begin
        if (!prev_valid) first_wb_cyc <= cyc;
        chk("wb_in_ready_low", io.in_ready, 1'b0);
        if (stall) begin
          chk("stall_tag", io.wb_tag, st_tag);
          chk("stall_data", io.wb_data, st_data);
          chk("stall_err", io.wb_err, st_err);
        end
        if (io.wb_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_spurious actual=valid required=idle tag=%0h", io.wb_tag);
          end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_tag", io.wb_tag, e.tag);
            chk("wb_data", io.wb_data, e.data);
            chk("wb_err", io.wb_err, e.err);
            hs_count <= hs_count + 1;
          end
          last_data <= io.wb_data;
          last_err  <= io.wb_err;
          stall     <= 1'b0;
        end else begin
          stall   <= 1'b1;
          st_tag  <= io.wb_tag;
          st_data <= io.wb_data;
          st_err  <= io.wb_err;
        end
      end else begin
        chk("idle_wb_err", io.wb_err, 1'b0);
        stall <= 1'b0;
      end
      prev_valid <= io.wb_valid;
    end
  end

  logic [1:0]       cur_unit;
  logic [3:0]       cur_op;
  logic [W-1:0]     cur_a, cur_b;
  logic [TAG_W-1:0] cur_tag;
  logic             cur_hi;

  task automatic drive(input logic [1:0] unit, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TAG_W-1:0] tag, input logic hi);
    cur_unit = unit; cur_op = op; cur_a = a; cur_b = b; cur_tag = tag; cur_hi = hi;
    io.in_unit = unit; io.in_op = op; io.in_a = a; io.in_b = b; io.in_tag = tag;
    io.in_mul_hi = hi;
    io.in_valid = 1'b1;
  endtask

  // Called between a negedge and the accepting posedge.
  task automatic finish_accept();
    acc_cyc = cyc;
    exp_q.push_back(model(cur_unit, cur_op, cur_a, cur_b, cur_tag, cur_hi));
    pushed++;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] unit, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TAG_W-1:0] tag, input logic hi);
    int n = 0;
    @(posedge clk);
    #1;
    drive(unit, op, a, b, tag, hi);
    @(negedge clk);
    #1;
    while (!io.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", io.in_ready, 1'b1);
    if (io.in_ready) finish_accept();
    else io.in_valid = 1'b0;
  endtask

  task automatic wait_wb(input string name);
    int n = 0;
    int rh = 0;
    while (hs_count < pushed && n < 200) begin
      @(negedge clk);
      #1;
      if (hs_count < pushed && io.in_ready) rh++;
      n++;
    end
    chk({name, "_wb_done"}, (hs_count >= pushed), 1'b1);
    chk({name, "_in_ready_busy"}, rh, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1;
    int n;
    rst = 1'b1;
    io.in_valid = 1'b0; io.in_unit = 2'b00; io.in_op = 4'd0; io.in_a = '0; io.in_b = '0;
    io.in_tag = '0; io.in_mul_hi = 1'b0; io.wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", io.in_ready, 1'b0);
    chk("rst_wb_valid", io.wb_valid, 1'b0);
    chk("rst_wb_err", io.wb_err, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_wb_tag", io.wb_tag, 6'd0);
    chk("rst_wb_data", io.wb_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // IALU ADD 5+7
    issue(2'b00, 4'd0, 64'd5, 64'd7, 6'd3, 1'b0);
    wait_wb("t1");
    chk("t1_latency", first_wb_cyc - acc_cyc, ALU_LAT + 1);
    chk("t1_data_lit", last_data, 64'd12);

    // IALU mix, back-to-back offers
    issue(2'b00, 4'd1, 64'd3, 64'd5, 6'd1, 1'b0);
    a1 = acc_cyc;
    issue(2'b00, 4'd2, 64'hAAAA_5555_F0F0_0F0F, 64'h0FF0_0FF0_0FF0_0FF0, 6'd2, 1'b0);
    chk("b2b_spacing", acc_cyc - a1, ALU_LAT + 2);
    issue(2'b00, 4'd3, 64'h8000_0000_0000_0000, 64'd1, 6'd63, 1'b0);
    issue(2'b00, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 6'd7, 1'b0);
    wait_wb("ialu_mix");
    chk("ialu_latency", first_wb_cyc - acc_cyc, ALU_LAT + 1);
    chk("xor_data_lit", last_data, 64'hEDCB_A987_6543_210F);

    // IMUL 2^40 * 2^40 with hi select, then a small product
    issue(2'b01, 4'd0, 64'h100_0000_0000, 64'h100_0000_0000, 6'd10, 1'b1);
    wait_wb("t2");
    chk("t2_data_lit", last_data, HI_EN ? 64'h1_0000 : 64'h0);
    issue(2'b01, 4'd0, 64'd3, 64'd5, 6'd11, 1'b0);
    wait_wb("t2b");
    chk("t2b_data_lit", last_data, 64'd15);
    chk("t2b_latency", first_wb_cyc - acc_cyc, ALU_LAT + 1);

    // IDIV 100/7 with a 10-cycle busy divider
    @(posedge clk);
    #1;
    busy_len = 10;
    ds_count = 0;
    issue(2'b10, 4'd0, 64'd100, 64'd7, 6'd4, 1'b0);
    wait_wb("t3");
    chk("t3_latency", first_wb_cyc - acc_cyc, 13);
    chk("t3_data_lit", last_data, 64'd14);
    chk("t3_div_start_count", ds_count, 1);

    // IDIV by zero with a divider that never raises busy
    @(posedge clk);
    #1;
    busy_len = 0;
    issue(2'b10, 4'd0, 64'd55, 64'd0, 6'd8, 1'b0);
    wait_wb("t3b");
    chk("t3b_latency", first_wb_cyc - acc_cyc, 4);
    chk("t3b_data_lit", last_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Writeback backpressure
    @(posedge clk);
    #1;
    io.wb_ready = 1'b0;
    issue(2'b00, 4'd4, 64'hF0F0, 64'h0FF0, 6'd21, 1'b0);
    n = 0;
    while (!io.wb_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_wb_seen", io.wb_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t4_hold_valid", io.wb_valid, 1'b1);
      chk("t4_hold_in_ready", io.in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    io.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t4_idle_valid", io.wb_valid, 1'b0);
    chk("t4_idle_in_ready", io.in_ready, 1'b1);
    chk("t4_data_lit", last_data, 64'hFF00);
    chk("t4_hs", hs_count, pushed);

    // Reset in DWAIT while the divider stays busy, then a new DIV
    @(posedge clk);
    #1;
    busy_len = 20;
    issue(2'b10, 4'd0, 64'd50, 64'd5, 6'd12, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    busy_len = 3;
    rst = 1'b1;
    exp_q.delete();
    pushed = hs_count;
    ds_count = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(2'b10, 4'd0, 64'd81, 64'd9, 6'd5, 1'b0);
    n = 0;
    @(negedge clk);
    #1;
    while (div_busy && n < 100) begin
      chk("t5_in_ready_while_busy", io.in_ready, 1'b0);
      n++;
      @(negedge clk);
      #1;
    end
    chk("t5_in_ready_after_busy", io.in_ready, 1'b1);
    if (io.in_ready) finish_accept();
    else io.in_valid = 1'b0;
    wait_wb("t5");
    chk("t5_latency", first_wb_cyc - acc_cyc, 6);
    chk("t5_data_lit", last_data, 64'd9);
    chk("t5_div_start_count", ds_count, 1);

    // Illegal unit
    @(posedge clk);
    #1;
    ds_count = 0;
    issue(2'b11, 4'd0, 64'd123, 64'd4, 6'd9, 1'b0);
    wait_wb("t6");
    chk("t6_latency", first_wb_cyc - acc_cyc, 1);
    chk("t6_data_lit", last_data, 64'd0);
    chk("t6_err_lit", last_err, 1'b1);
    chk("t6_div_start_count", ds_count, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
